// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it, packed
// big-endian into 32-bit words, to the instruction memory. The CPU core is
// held in reset until the whole image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte after the image.
module imem_loader #(
    parameter int unsigned IMEM_SIZE = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Byte_Valid,
    input  logic [7:0]  Byte_Data,
    output logic        Byte_Ready,
    output logic [31:0] Load_PC,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic        CPU_RST,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [15:0] Word_Count
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_RECV   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FINAL  = S_CHK;
`else
    localparam logic [2:0] S_FINAL  = S_DONE;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_rx;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] word_sr;
    logic              accept;
    logic              last_word;
    logic              restart;
    logic              ready_nxt;
    logic              busy_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = Byte_Valid && Byte_Ready;
    assign len_rx    = {len_hi, Byte_Data};
    assign last_word = (Word_Count + 16'd1) == len;
    assign restart   = Start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and next-cycle status decode
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        case (state)
            S_IDLE:   if (Start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_rx > 16'(IMEM_SIZE)) state_nxt = S_ERR;
                    else if (len_rx == '0)       state_nxt = S_FINAL;
                    else                         state_nxt = S_RECV;
                end
            end
            S_RECV:   if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_word ? S_FINAL : S_RECV;
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_nxt = (Byte_Data == csum) ? S_DONE : S_ERR;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_DONE, S_ERR: if (Start) state_nxt = S_LEN_HI;
            default:  state_nxt = S_IDLE;
        endcase
        case (state_nxt)
            S_LEN_HI, S_LEN_LO, S_RECV, S_CHK: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            S_WRITE: busy_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            Byte_Ready <= 1'b0;
            WE         <= 1'b0;
            Load_PC    <= '0;
            W_Ins      <= '0;
            Word_Count <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            CPU_RST    <= 1'b1;
            len_hi     <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            Byte_Ready <= ready_nxt;
            Busy       <= busy_nxt;
            WE         <= (state_nxt == S_WRITE);
            Done       <= (state_nxt == S_DONE);
            Err        <= (state_nxt == S_ERR);
            CPU_RST    <= (state_nxt != S_DONE);

            if (accept && (state == S_LEN_HI)) len_hi <= Byte_Data;
            if (accept && (state == S_LEN_LO)) len    <= len_rx;

            if (accept && (state == S_RECV)) begin
                word_sr  <= {word_sr[23:0], Byte_Data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ Byte_Data;
`endif
                if (byte_cnt == 2'd3) begin
                    Load_PC <= 32'({Word_Count, 2'b00});
                    W_Ins   <= {word_sr[23:0], Byte_Data};
                end
            end

            if (state == S_WRITE) Word_Count <= Word_Count + 16'd1;

            if (restart) begin
                Word_Count <= '0;
                byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams, a write-list model
// derived from the byte stream, and a monitor that checks every WE pulse.
module tb_imem_loader;

    localparam int unsigned IMEM_SIZE = 128;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic        Byte_Valid = 1'b0;
    logic [7:0]  Byte_Data = 8'h00;
    logic        Byte_Ready;
    logic [31:0] Load_PC;
    logic [31:0] W_Ins;
    logic        WE;
    logic        CPU_RST;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] Word_Count;

    imem_loader #(.IMEM_SIZE(IMEM_SIZE)) dut (
        .CLK(CLK), .RST(RST), .Start(Start),
        .Byte_Valid(Byte_Valid), .Byte_Data(Byte_Data), .Byte_Ready(Byte_Ready),
        .Load_PC(Load_PC), .W_Ins(W_Ins), .WE(WE), .CPU_RST(CPU_RST),
        .Busy(Busy), .Done(Done), .Err(Err), .Word_Count(Word_Count)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          we_count = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          we_snap = 0;
    int          we_cyc[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_word[$];
    logic [31:0] mon_pc;
    logic [31:0] mon_word;
    logic [31:0] mem [0:IMEM_SIZE-1];
    logic [7:0]  stim[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every WE pulse must match the next expected write of the model
    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            we_count++;
            we_cyc.push_back(cyc);
            chk("we_ready_low", 32'(Byte_Ready), 32'd0);
            chk("we_cpu_rst", 32'(CPU_RST), 32'd1);
            if (exp_pc.size() == 0) begin
                chk("we_unexpected", 32'(WE), 32'd0);
            end else begin
                mon_pc   = exp_pc.pop_front();
                mon_word = exp_word.pop_front();
                chk("we_load_pc", Load_PC, mon_pc);
                chk("we_w_ins", W_Ins, mon_word);
                chk("we_word_count", 32'(Word_Count), mon_pc >> 2);
            end
            if (Load_PC[31:9] == '0) mem[Load_PC[8:2]] = W_Ins;
        end
    end

    // Model: word i of the image is bytes 4i..4i+3 after the length, MSB first
    task automatic model_writes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(32'(4 * i));
            exp_word.push_back({stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
        end
    endtask

    function automatic logic [7:0] image_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= stim[2+i];
        return x;
    endfunction

    task automatic add_csum(input int n, input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(image_xor(n) ^ flip);
`else
        if (flip != 8'h00 && n < 0) stim.push_back(8'h00);
`endif
    endtask

    task automatic start_load();
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        start_cyc = cyc;
        we_cyc.delete();
        chk("start_busy", 32'(Busy), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int t = 0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                Byte_Valid = 1'b0;
                @(negedge CLK);
            end
        end
        Byte_Valid = 1'b1;
        Byte_Data  = b;
        while (!Byte_Ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("byte_accept", 32'(Byte_Ready), 32'd1);
        @(negedge CLK);
    endtask

    task automatic send_stim(input bit rnd);
        foreach (stim[i]) send_byte(stim[i], rnd);
        Byte_Valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(Done || Err) && t < 100) begin
            @(negedge CLK);
            t++;
        end
        done_cyc = cyc;
        chk("finish_timeout", 32'(Done || Err), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_byte_ready"}, 32'(Byte_Ready), 32'd0);
        chk({tag, "_we"}, 32'(WE), 32'd0);
        chk({tag, "_load_pc"}, Load_PC, 32'd0);
        chk({tag, "_w_ins"}, W_Ins, 32'd0);
        chk({tag, "_word_count"}, 32'(Word_Count), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(CPU_RST), 32'd1);
    endtask

    task automatic check_done(input string tag, input int n);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(CPU_RST), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_word_count"}, 32'(Word_Count), 32'(n));
        chk({tag, "_all_written"}, 32'(exp_pc.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Two words, source always valid
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        model_writes(2);
        add_csum(2, 8'h00);
        start_load();
        send_stim(1'b0);
        wait_done();
        check_done("steady", 2);
        chk("steady_mem0", mem[0], 32'h12345678);
        chk("steady_mem1", mem[1], 32'h9ABCDEF0);
        chk("steady_we_pulses", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2) begin
            chk("steady_first_we_latency", 32'(we_cyc[0] - start_cyc), 32'd6);
            chk("steady_word_period", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk("steady_done_latency", 32'(done_cyc - we_cyc[1]), 32'd1);
`endif
        end
        chk("steady_load_pc_hold", Load_PC, 32'd4);
        chk("steady_w_ins_hold", W_Ins, 32'h9ABCDEF0);

        // Length one above the memory depth
        we_snap = we_count;
        stim = '{8'h00, 8'h81};
        start_load();
        send_stim(1'b0);
        chk("ovf_err", 32'(Err), 32'd1);
        chk("ovf_busy", 32'(Busy), 32'd0);
        chk("ovf_cpu_rst", 32'(CPU_RST), 32'd1);
        chk("ovf_done", 32'(Done), 32'd0);
        chk("ovf_ready", 32'(Byte_Ready), 32'd0);
        chk("ovf_word_count", 32'(Word_Count), 32'd0);
        repeat (5) @(negedge CLK);
        chk("ovf_no_we", 32'(we_count - we_snap), 32'd0);
        chk("ovf_err_hold", 32'(Err), 32'd1);

        // Empty image
        we_snap = we_count;
        stim = '{8'h00, 8'h00};
        add_csum(0, 8'h00);
        start_load();
        chk("zero_err_cleared", 32'(Err), 32'd0);
        send_stim(1'b0);
        check_done("zero", 0);
        chk("zero_no_we", 32'(we_count - we_snap), 32'd0);

        // Image exactly filling the memory
        stim = '{8'h00, 8'h80};
        for (int i = 0; i < 4 * IMEM_SIZE; i++) stim.push_back(8'(i * 7 + 3));
        model_writes(IMEM_SIZE);
        add_csum(IMEM_SIZE, 8'h00);
        start_load();
        send_stim(1'b0);
        wait_done();
        check_done("full", IMEM_SIZE);
        chk("full_last_pc", Load_PC, 32'h0000_01FC);
        chk("full_mem0", mem[0], 32'h030A_1118);

        // Irregular source, bytes held across WRITE
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        model_writes(2);
        add_csum(2, 8'h00);
        mem[0] = '0;
        mem[1] = '0;
        start_load();
        send_stim(1'b1);
        wait_done();
        check_done("rnd", 2);
        chk("rnd_mem0", mem[0], 32'h12345678);
        chk("rnd_mem1", mem[1], 32'h9ABCDEF0);

        // Reset after six data bytes of a two-word load
        stim = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        model_writes(1);
        we_snap = we_count;
        start_load();
        send_stim(1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check_reset("midrst");
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_we_total", 32'(we_count - we_snap), 32'd1);
        chk("midrst_mem0", mem[0], 32'hA1A2A3A4);
        chk("midrst_pending", 32'(exp_pc.size()), 32'd0);
        stim = '{8'h00, 8'h01, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        model_writes(1);
        add_csum(1, 8'h00);
        start_load();
        send_stim(1'b0);
        wait_done();
        check_done("reload", 1);
        chk("reload_mem0", mem[0], 32'hC1C2C3C4);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum byte matching and not matching
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        chk("csum_model_pin", 32'(image_xor(1)), 32'h44);
        model_writes(1);
        start_load();
        send_stim(1'b0);
        check_done("csum_ok", 1);
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        model_writes(1);
        start_load();
        send_stim(1'b0);
        chk("csum_bad_err", 32'(Err), 32'd1);
        chk("csum_bad_cpu_rst", 32'(CPU_RST), 32'd1);
        chk("csum_bad_done", 32'(Done), 32'd0);
`endif

        repeat (3) @(negedge CLK);
        chk("no_stray_writes", 32'(exp_pc.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader sitting directly upstream of the single-cycle MIPS instruction memory. It accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit instruction words. It drives the instruction memory's write address, write data and write enable, and holds the CPU core in reset until the image is fully written. The instruction memory's own reset is tied to `RST`, so its write path stays enabled while the core's reset is asserted.

## Interface
Parameters:
- `IMEM_SIZE`, 128, instruction memory depth in words; the upper bound on the image length.

Ports:
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Start` in 1: load request; sampled only in IDLE, DONE and ERR.
- `Byte_Valid` in 1: the source presents a byte.
- `Byte_Data` in 8: the byte presented by the source.
- `Byte_Ready` out 1: the loader can accept a byte; a transfer occurs when `Byte_Valid && Byte_Ready`.
- `Load_PC` out 32: byte address to the instruction memory's PC input while loading; equals word index << 2.
- `W_Ins` out 32: instruction word to be written.
- `WE` out 1: instruction memory write enable; a one-cycle pulse per word.
- `CPU_RST` out 1: reset to the CPU core; high in every state except DONE.
- `Busy` out 1: high in LEN_HI, LEN_LO, RECV, WRITE and CHK.
- `Done` out 1: high in DONE.
- `Err` out 1: high in ERR.
- `Word_Count` out 16: number of words written in the current load.

## Operation
- Stream format:
  - length high byte, then length low byte, giving N (16-bit word count);
  - then 4·N data bytes, big-endian, so the first byte of each word lands in [31:24];
  - then one checksum byte, only when CHECKSUM is compiled in.
- States: IDLE, LEN_HI, LEN_LO, RECV, WRITE, CHK, DONE, ERR.
- IDLE -> LEN_HI on `Start`.
- LEN_HI -> LEN_LO on an accepted byte.
- LEN_LO, on an accepted byte, goes to:
  - ERR if N > `IMEM_SIZE`;
  - DONE if N == 0 (CHK instead when CHECKSUM is enabled);
  - RECV otherwise.
- RECV:
  - shifts accepted bytes into the word register and counts them with a 2-bit byte counter;
  - goes to WRITE on acceptance of the 4th byte.
- WRITE:
  - lasts exactly one cycle, with `WE`=1, `Load_PC`={idx,2'b00} and `W_Ins`=the assembled word;
  - then idx and `Word_Count` increment;
  - goes to DONE/CHK if idx+1 == N, otherwise back to RECV.
- DONE and ERR hold until `Start`, which clears idx, `Word_Count`, `Err` and the checksum, then goes to LEN_HI.
- `Start` is ignored in all Busy states.
- `Byte_Ready`=1 in LEN_HI, LEN_LO, RECV and CHK; 0 elsewhere, including in WRITE, which back-pressures the source.
- Bytes presented while `Byte_Ready`=0 are not consumed.
- In ERR no further writes occur; words already written stay in memory and `CPU_RST` stays 1.
- `RST` mid-load: return to IDLE immediately. Memory contents already written are untouched. No `WE` pulse is issued in the reset cycle.

## Timing
- All outputs are registered.
- Reset values: `Byte_Ready`=0, `WE`=0, `Load_PC`=0, `W_Ins`=0, `Word_Count`=0, `Busy`=0, `Done`=0, `Err`=0, `CPU_RST`=1.
- Latency with `Byte_Valid` held high:
  - 4th byte of a word accepted at edge k -> `WE` high during cycle k+1;
  - the next byte can be accepted at edge k+2;
  - a full word costs 5 cycles.
- `Load_PC` and `W_Ins` are stable throughout the `WE` cycle, and hold their last values after it.
- Last `WE` at cycle k -> `Done`=1 and `CPU_RST`=0 from edge k+1 (no CHK).
- `Word_Count` equals N once in DONE.
- Index wrap-around cannot occur because N ≤ `IMEM_SIZE` is enforced.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - the loader keeps a running XOR of all data bytes (length bytes excluded);
  - after the last word it enters CHK and accepts one byte;
  - equal to the running XOR -> DONE; different -> ERR.
  - For N=0 the expected checksum is 8'h00.
- Undefined: no CHK state and no checksum byte; the last WRITE goes directly to DONE.

## Test plan
- Reset then `Start`, stream 00 02 / 12 34 56 78 / 9A BC DE F0 with `Byte_Valid` held high:
  - `WE` pulses twice: (`Load_PC`=0, `W_Ins`=32'h12345678) and (`Load_PC`=4, `W_Ins`=32'h9ABCDEF0);
  - then `Done`=1, `CPU_RST`=0, `Word_Count`=2.
- Length 00 81 with `IMEM_SIZE`=128:
  - ERR entered right after the second length byte;
  - `Err`=1, no `WE` pulse, `CPU_RST`=1.
- Length 00 00:
  - DONE in the cycle after the length low byte;
  - `Word_Count`=0, no `WE` pulse.
  - With checksum enabled, checksum byte 00 -> DONE.
- `Byte_Valid` toggled randomly and a byte held during WRITE:
  - the byte is accepted only after WRITE ends;
  - written words are identical to the steady-stream case.
- `RST` asserted after 6 data bytes of a 2-word load:
  - IDLE next cycle, all outputs at reset values, word 0 retained in memory;
  - a subsequent `Start` reloads from index 0.
- With `IMEM_LOADER_CHECKSUM_EN` and one word 11 22 33 44:
  - checksum 44 -> DONE;
  - checksum 45 -> `Err`=1 and `CPU_RST`=1.
